alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational 8-bit ALU.
- Extends the existing 3-bit op set to 4 bits:
  - carry-chained ADC/SBC
  - shifts
  - compare
  - multi-cycle unsigned multiply
- Result and flags are registered; a persistent flags register feeds ADC/SBC.
- Sits between the decode/operand-fetch stage and register writeback.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_seq.sv | 69 ++++++
 rtl/alu_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_pipe.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op codes, FSM states and flag bit positions.
// Op codes 0-7 match the original combinational 8-bit ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_XOR   = 4'h2;
  localparam logic [3:0] OP_NOTA  = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_INC   = 4'h6;
  localparam logic [3:0] OP_DEC   = 4'h7;
  localparam logic [3:0] OP_ADC   = 4'h8;
  localparam logic [3:0] OP_SBC   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_ASR   = 4'hC;
  localparam logic [3:0] OP_CMP   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier. The first partial product is taken on the
// start edge, so the full product is ready after WIDTH clock edges in total.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  // Iteration step: add shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : {(2*WIDTH){1'b0}};
      mcand_d  = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CW'(WIDTH - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      run_d    = (cnt_q != CW'(1));
    end else begin
      run_d    = 1'b0;
    end
  end

  // Multiplier state; reset aborts an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign last_o = run_q && (cnt_q == CW'(1));
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags, carry-chained ADC/SBC and a
// multi-cycle multiply. The flags register doubles as the architectural carry.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output logic             zero,
  output logic             ovf,
  output logic             neg,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic               out_free_s, accept_s, mul_start_s, mul_last_s;
  logic               load_alu_s, load_mul_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   alu_res_s, opb_s;
  logic [WIDTH:0]     sum_s;
  logic               alu_c_s, alu_v_s, arith_s, sub_s, cin_s, clr_s;

  assign out_free_s  = !out_valid_q || out_ready;
  assign in_ready    = (state_q == ST_IDLE) && out_free_s;
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (op == OP_MUL) && (MUL_EN != 0);
  assign load_alu_s  = accept_s && !mul_start_s;
  assign load_mul_s  = (state_q == ST_DONE) && out_free_s;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start_s),
    .a_i     (a),
    .b_i     (b),
    .last_o  (mul_last_s),
    .prod_o  (prod_s)
  );

  // Single-cycle datapath; CMP leaves the difference in alu_res_s for flag generation only.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    opb_s     = b;
    arith_s   = 1'b0;
    sub_s     = 1'b0;
    cin_s     = 1'b0;
    clr_s     = 1'b0;
    sum_s     = {(WIDTH+1){1'b0}};
    case (op)
      OP_AND:   alu_res_s = a & b;
      OP_OR:    alu_res_s = a | b;
      OP_XOR:   alu_res_s = a ^ b;
      OP_NOTA:  alu_res_s = ~a;
      OP_ADD:   arith_s = 1'b1;
      OP_SUB:   begin arith_s = 1'b1; sub_s = 1'b1; end
      OP_INC:   begin arith_s = 1'b1; opb_s = {{M{1'b0}}, 1'b1}; end
      OP_DEC:   begin arith_s = 1'b1; sub_s = 1'b1; opb_s = {{M{1'b0}}, 1'b1}; end
      OP_ADC:   begin arith_s = 1'b1; cin_s = flags_q[FLAG_C]; end
      OP_SBC:   begin arith_s = 1'b1; sub_s = 1'b1; cin_s = flags_q[FLAG_C]; end
      OP_SHL:   begin alu_res_s = {a[M-1:0], 1'b0}; alu_c_s = a[M]; end
      OP_SHR:   begin alu_res_s = {1'b0, a[M:1]}; alu_c_s = a[0]; end
      OP_ASR:   begin alu_res_s = {a[M], a[M:1]}; alu_c_s = a[0]; end
      OP_CMP:   begin arith_s = 1'b1; sub_s = 1'b1; end
      OP_MUL:   begin alu_res_s = b; clr_s = 1'b1; end
      OP_PASSB: alu_res_s = b;
      default:  alu_res_s = {WIDTH{1'b0}};
    endcase
    if (arith_s) begin
      if (sub_s) begin
        sum_s   = {1'b0, a} - {1'b0, opb_s} - {{WIDTH{1'b0}}, cin_s};
        alu_v_s = (a[M] != opb_s[M]) && (sum_s[M] != a[M]);
      end else begin
        sum_s   = {1'b0, a} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin_s};
        alu_v_s = (a[M] == opb_s[M]) && (sum_s[M] != a[M]);
      end
      alu_res_s = sum_s[M:0];
      alu_c_s   = sum_s[WIDTH];
    end else begin
      sum_s = {(WIDTH+1){1'b0}};
    end
  end

  // Output register, flags register and control FSM next state.
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (load_alu_s) begin
      res_d           = (op == OP_CMP) ? res_q : alu_res_s;
      flags_d[FLAG_C] = alu_c_s;
      flags_d[FLAG_V] = alu_v_s;
      flags_d[FLAG_Z] = !clr_s && (alu_res_s == {WIDTH{1'b0}});
      flags_d[FLAG_N] = !clr_s && alu_res_s[M];
      out_valid_d     = 1'b1;
    end else if (load_mul_s) begin
      res_d           = prod_s[M:0];
      flags_d[FLAG_C] = |prod_s[2*WIDTH-1:WIDTH];
      flags_d[FLAG_V] = 1'b0;
      flags_d[FLAG_Z] = (prod_s[M:0] == {WIDTH{1'b0}});
      flags_d[FLAG_N] = prod_s[M];
      out_valid_d     = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      ST_IDLE: state_d = mul_start_s ? ST_MUL : ST_IDLE;
      ST_MUL:  state_d = mul_last_s ? ST_DONE : ST_MUL;
      ST_DONE: state_d = load_mul_s ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_q       <= {WIDTH{1'b0}};
      flags_q     <= {FLAG_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign c_out     = flags_q[FLAG_C];
  assign zero      = flags_q[FLAG_Z];
  assign ovf       = flags_q[FLAG_V];
  assign neg       = flags_q[FLAG_N];
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8, MUL_EN=1).
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, res;
  logic [3:0] op;
  logic       c_out, zero, ovf, neg, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .c_out     (c_out),
    .zero      (zero),
    .ovf       (ovf),
    .neg       (neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for a single clock edge; returns 1 time unit after that edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp_nvzc);
    check(tag, {28'd0, neg, ovf, zero, c_out}, {28'd0, exp_nvzc});
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; op = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res", {24'd0, res}, 32'h00);
    check_flags("rst_flags", 4'b0000);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a multiply
    issue(4'hE, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1 check("mulabort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mulabort_out_valid", {31'd0, out_valid}, 32'd0);
    check("mulabort_busy_clr", {31'd0, busy}, 32'd0);
    check_flags("mulabort_flags", 4'b0000);
    issue(4'h4, 8'h01, 8'h01);
    check("add11_valid", {31'd0, out_valid}, 32'd1);
    check("add11_res", {24'd0, res}, 32'h02);
    check_flags("add11_flags", 4'b0000);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_stale_mul", seen, 32'd0);

    // ADD then ADC using the stored carry
    issue(4'h4, 8'hFF, 8'h01);
    check("add_res", {24'd0, res}, 32'h00);
    check_flags("add_flags", 4'b0011);
    issue(4'h8, 8'h00, 8'h00);
    check("adc_res", {24'd0, res}, 32'h01);
    check_flags("adc_flags", 4'b0000);

    // SUB overflow, then CMP keeps res
    issue(4'h5, 8'h80, 8'h01);
    check("sub_res", {24'd0, res}, 32'h7F);
    check_flags("sub_flags", 4'b0100);
    issue(4'hD, 8'h05, 8'h07);
    check("cmp_res_held", {24'd0, res}, 32'h7F);
    check_flags("cmp_flags", 4'b1001);
    check("cmp_valid", {31'd0, out_valid}, 32'd1);

    // Multiply: busy for 8 cycles, result on the 9th
    issue(4'hE, 8'h12, 8'h34);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul_busy_%0d", i), {30'd0, busy, in_ready}, 32'b10);
      check($sformatf("mul_nvalid_%0d", i), {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("mul_valid", {31'd0, out_valid}, 32'd1);
    check("mul_res", {24'd0, res}, 32'hA8);
    check_flags("mul_flags", 4'b1001);
    check("mul_idle", {30'd0, busy, in_ready}, 32'b01);

    // Backpressure: XOR result held, pending ADD ignored until out_ready rises
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'h2, 8'hF0, 8'h3C);
    op = 4'h4; a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_res_%0d", i), {24'd0, res}, 32'hCC);
      check($sformatf("bp_hs_%0d", i), {30'd0, out_valid, in_ready}, 32'b10);
      check_flags($sformatf("bp_flags_%0d", i), 4'b1000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 check("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_res", {24'd0, res}, 32'h00);
    check_flags("bp_new_flags", 4'b0011);

    // Shifts
    issue(4'hC, 8'h81, 8'h00);
    check("asr_res", {24'd0, res}, 32'hC0);
    check_flags("asr_flags", 4'b1001);
    issue(4'hB, 8'h81, 8'h00);
    check("shr_res", {24'd0, res}, 32'h40);
    check_flags("shr_flags", 4'b0001);
    issue(4'hA, 8'h80, 8'h00);
    check("shl_res", {24'd0, res}, 32'h00);
    check_flags("shl_flags", 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
